// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: drives the ALU, holds acc/carry and an IL parenthesis stack.
// Ports: i_clk/i_reset (sync, active-high); cmd valid/ready handshake with
//   i_cmdType (00 EXEC,01 PUSH,10 POP,11 CLRF), i_cmdOpcode, i_cmdOperand;
//   o_aluOpcode/o_aluOp1/o_aluOp2/o_aluEn to the ALU, i_aluResult/i_aluCarry
//   back; o_acc, o_carryFlag, o_stackDepth, sticky o_stackOvf/o_stackUnf.
// Optional macro ACC_ZERO_FLAG_EN adds o_zeroFlag (acc==0, reset value 1).

`ifndef aluOpcodeLen
`define aluOpcodeLen 4
`endif
`ifndef AND_alu
`define AND_alu 0
`endif
`ifndef OR_alu
`define OR_alu 1
`endif
`ifndef XOR_alu
`define XOR_alu 2
`endif
`ifndef ADD_alu
`define ADD_alu 3
`endif
`ifndef SUB_alu
`define SUB_alu 4
`endif
`ifndef LT_alu
`define LT_alu 5
`endif
`ifndef EQ_alu
`define EQ_alu 6
`endif
`ifndef LD_data
`define LD_data 7
`endif

module alu_acc_ctrl #(
   parameter int OPC_W   = `aluOpcodeLen,
   parameter int DEPTH   = 4,
   parameter int DEPTH_W = 3
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_cmdValid,
   output logic               o_cmdReady,
   input  logic [1:0]         i_cmdType,
   input  logic [OPC_W-1:0]   i_cmdOpcode,
   input  logic [7:0]         i_cmdOperand,
   output logic [OPC_W-1:0]   o_aluOpcode,
   output logic [7:0]         o_aluOp1,
   output logic [7:0]         o_aluOp2,
   output logic               o_aluEn,
   input  logic [7:0]         i_aluResult,
   input  logic               i_aluCarry,
   output logic [7:0]         o_acc,
   output logic               o_carryFlag,
   output logic [DEPTH_W-1:0] o_stackDepth,
   output logic               o_stackOvf,
`ifdef ACC_ZERO_FLAG_EN
   output logic               o_zeroFlag,
`endif
   output logic               o_stackUnf
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_POPX} state_t;

   state_t             r_state;
   logic               r_cmdReady;
   logic [OPC_W-1:0]   r_aluOpcode;
   logic [7:0]         r_aluOp1;
   logic [7:0]         r_aluOp2;
   logic               r_aluEn;
   logic [7:0]         r_acc;
   logic               r_carry;
   logic [DEPTH_W-1:0] r_depth;
   logic               r_ovf;
   logic               r_unf;
   logic               r_zero;
   logic [7:0]         r_stkAcc [DEPTH];
   logic [OPC_W-1:0]   r_stkOpc [DEPTH];

   logic               w_accept;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_carryOp;
   logic [IDX_W-1:0]   w_top;

   assign w_accept  = i_cmdValid & r_cmdReady;
   assign w_full    = (r_depth == DEPTH_W'(DEPTH));
   assign w_empty   = (r_depth == '0);
   assign w_push    = w_accept & (i_cmdType == 2'b01) & ~w_full;
   assign w_top     = IDX_W'(r_depth - DEPTH_W'(1));
   // Only arithmetic ops own the carry; logic/compare ops leave it alone.
   assign w_carryOp = (r_aluOpcode == OPC_W'(`ADD_alu)) |
                      (r_aluOpcode == OPC_W'(`SUB_alu));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_cmdReady  <= 1'b0;
         r_aluOpcode <= '0;
         r_aluOp1    <= '0;
         r_aluOp2    <= '0;
         r_aluEn     <= 1'b0;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_depth     <= '0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_zero      <= 1'b1;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_cmdReady <= 1'b1;
               if (w_accept) begin
                  case (i_cmdType)
                     2'b00: begin
                        r_aluOpcode <= i_cmdOpcode;
                        if (i_cmdOpcode == OPC_W'(`LD_data)) begin
                           r_aluOp1 <= i_cmdOperand;
                           r_aluOp2 <= '0;
                        end else begin
                           r_aluOp1 <= r_acc;
                           r_aluOp2 <= i_cmdOperand;
                        end
                        r_aluEn    <= 1'b1;
                        r_cmdReady <= 1'b0;
                        r_state    <= S_EXEC;
                     end
                     2'b01: begin
                        if (w_full) r_ovf <= 1'b1;
                        else r_depth <= r_depth + DEPTH_W'(1);
                     end
                     2'b10: begin
                        if (w_empty) begin
                           r_unf <= 1'b1;
                        end else begin
                           r_aluOpcode <= r_stkOpc[w_top];
                           r_aluOp1    <= r_stkAcc[w_top];
                           r_aluOp2    <= r_acc;
                           r_aluEn     <= 1'b1;
                           r_cmdReady  <= 1'b0;
                           r_state     <= S_POPX;
                        end
                     end
                     default: begin
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                     end
                  endcase
               end
            end
            S_EXEC, S_POPX: begin
               r_acc  <= i_aluResult;
               r_zero <= (i_aluResult == 8'h00);
               if (w_carryOp) r_carry <= i_aluCarry;
               if (r_state == S_POPX) r_depth <= r_depth - DEPTH_W'(1);
               r_aluEn    <= 1'b0;
               r_cmdReady <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Stack storage needs no reset; depth alone decides validity.
   always_ff @(posedge i_clk) begin
      if (!i_reset && w_push) begin
         r_stkAcc[r_depth[IDX_W-1:0]] <= r_acc;
         r_stkOpc[r_depth[IDX_W-1:0]] <= i_cmdOpcode;
      end
   end

   assign o_cmdReady   = r_cmdReady;
   assign o_aluOpcode  = r_aluOpcode;
   assign o_aluOp1     = r_aluOp1;
   assign o_aluOp2     = r_aluOp2;
   assign o_aluEn      = r_aluEn;
   assign o_acc        = r_acc;
   assign o_carryFlag  = r_carry;
   assign o_stackDepth = r_depth;
   assign o_stackOvf   = r_ovf;
   assign o_stackUnf   = r_unf;
`ifdef ACC_ZERO_FLAG_EN
   assign o_zeroFlag   = r_zero;
`else
   logic w_unusedZero;
   assign w_unusedZero = r_zero;
`endif

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb_alu_acc_ctrl: directed test of alu_acc_ctrl with a behavioural ALU.
// Ports: none (top-level bench).
module tb_alu_acc_ctrl;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_LT  = 4'd5;
   localparam logic [3:0] OP_LD  = 4'd7;

   localparam logic [1:0] C_EXEC = 2'b00;
   localparam logic [1:0] C_PUSH = 2'b01;
   localparam logic [1:0] C_POP  = 2'b10;
   localparam logic [1:0] C_CLRF = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmdValid;
   logic       cmdReady;
   logic [1:0] cmdType;
   logic [3:0] cmdOpcode;
   logic [7:0] cmdOperand;
   logic [3:0] aluOpcode;
   logic [7:0] aluOp1;
   logic [7:0] aluOp2;
   logic       aluEn;
   logic [7:0] aluResult;
   logic       aluCarry;
   logic [7:0] acc;
   logic       carryFlag;
   logic [2:0] stackDepth;
   logic       stackOvf;
   logic       stackUnf;
`ifdef ACC_ZERO_FLAG_EN
   logic       zeroFlag;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_acc_ctrl #(.OPC_W(4), .DEPTH(4), .DEPTH_W(3)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_cmdValid   (cmdValid),
      .o_cmdReady   (cmdReady),
      .i_cmdType    (cmdType),
      .i_cmdOpcode  (cmdOpcode),
      .i_cmdOperand (cmdOperand),
      .o_aluOpcode  (aluOpcode),
      .o_aluOp1     (aluOp1),
      .o_aluOp2     (aluOp2),
      .o_aluEn      (aluEn),
      .i_aluResult  (aluResult),
      .i_aluCarry   (aluCarry),
      .o_acc        (acc),
      .o_carryFlag  (carryFlag),
      .o_stackDepth (stackDepth),
      .o_stackOvf   (stackOvf),
`ifdef ACC_ZERO_FLAG_EN
      .o_zeroFlag   (zeroFlag),
`endif
      .o_stackUnf   (stackUnf)
   );

   // Behavioural combinational ALU.
   always_comb begin
      logic [8:0] t;
      t         = 9'h000;
      aluResult = 8'h00;
      aluCarry  = 1'b0;
      case (aluOpcode)
         OP_AND: aluResult = aluOp1 & aluOp2;
         OP_OR:  aluResult = aluOp1 | aluOp2;
         OP_XOR: aluResult = aluOp1 ^ aluOp2;
         OP_ADD: begin
            t = {1'b0, aluOp1} + {1'b0, aluOp2};
            aluResult = t[7:0];
            aluCarry  = t[8];
         end
         OP_SUB: begin
            t = {1'b0, aluOp1} - {1'b0, aluOp2};
            aluResult = t[7:0];
            aluCarry  = t[8];
         end
         OP_LT:  aluResult = (aluOp1 < aluOp2) ? 8'h01 : 8'h00;
         OP_LD:  aluResult = aluOp1;
         default: aluResult = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits for ready, presents one command for one edge, returns at edge+1.
   task automatic issue(input logic [1:0] t, input logic [3:0] o,
                        input logic [7:0] d);
      int n = 0;
      while (!cmdReady && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (n < 20) else begin
         bad++;
         $error("FAIL ready_timeout observed=%0d expected=<20", n);
      end
      cmdValid   = 1'b1;
      cmdType    = t;
      cmdOpcode  = o;
      cmdOperand = d;
      @(posedge clk);
      #1;
      cmdValid   = 1'b0;
      cmdType    = 2'b00;
      cmdOpcode  = 4'hF;
      cmdOperand = 8'hEE;
   endtask

   // EXEC or successful POP: returns once the result is visible.
   task automatic run(input logic [1:0] t, input logic [3:0] o,
                      input logic [7:0] d);
      issue(t, o, d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      cmdValid   = 1'b0;
      cmdType    = 2'b00;
      cmdOpcode  = 4'h0;
      cmdOperand = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_acc", acc, 8'h00);
      check("rst_carry", carryFlag, 1'b0);
      check("rst_depth", stackDepth, 3'd0);
      check("rst_ovf", stackOvf, 1'b0);
      check("rst_unf", stackUnf, 1'b0);
      check("rst_aluEn", aluEn, 1'b0);
      check("rst_ready", cmdReady, 1'b0);
      check("rst_op1", aluOp1, 8'h00);
`ifdef ACC_ZERO_FLAG_EN
      check("rst_zero", zeroFlag, 1'b1);
`endif
      @(negedge clk);
      reset = 1'b0;

      // LD 5A: ALU driven one cycle, result one cycle later.
      issue(C_EXEC, OP_LD, 8'h5A);
      check("ld_aluEn", aluEn, 1'b1);
      check("ld_ready", cmdReady, 1'b0);
      check("ld_op1", aluOp1, 8'h5A);
      check("ld_op2", aluOp2, 8'h00);
      check("ld_opc", aluOpcode, OP_LD);
      check("ld_acc_old", acc, 8'h00);
      @(posedge clk);
      #1;
      check("ld_acc", acc, 8'h5A);
      check("ld_carry", carryFlag, 1'b0);
      check("ld_aluEn_off", aluEn, 1'b0);
      check("ld_ready_back", cmdReady, 1'b1);
      check("ld_hold_op1", aluOp1, 8'h5A);

      // ADD carry, then AND holds carry.
      run(C_EXEC, OP_LD, 8'hF0);
      run(C_EXEC, OP_ADD, 8'h20);
      check("add_acc", acc, 8'h10);
      check("add_carry", carryFlag, 1'b1);
      run(C_EXEC, OP_AND, 8'h0F);
      check("and_acc", acc, 8'h00);
      check("and_carry", carryFlag, 1'b1);
`ifdef ACC_ZERO_FLAG_EN
      check("and_zero", zeroFlag, 1'b1);
`endif

      // Parenthesis: 0C OR (30).
      run(C_EXEC, OP_LD, 8'h0C);
      issue(C_PUSH, OP_OR, 8'h00);
      check("push_depth", stackDepth, 3'd1);
      check("push_acc", acc, 8'h0C);
      check("push_ready", cmdReady, 1'b1);
      run(C_EXEC, OP_LD, 8'h30);
      issue(C_POP, 4'h0, 8'h00);
      check("pop_aluEn", aluEn, 1'b1);
      check("pop_opc", aluOpcode, OP_OR);
      check("pop_op1", aluOp1, 8'h0C);
      check("pop_op2", aluOp2, 8'h30);
      @(posedge clk);
      #1;
      check("pop_acc", acc, 8'h3C);
      check("pop_depth", stackDepth, 3'd0);

      // Fill, overflow, drain, underflow.
      issue(C_PUSH, OP_AND, 8'h00);
      issue(C_PUSH, OP_OR, 8'h00);
      issue(C_PUSH, OP_XOR, 8'h00);
      issue(C_PUSH, OP_ADD, 8'h00);
      check("full_ovf_pre", stackOvf, 1'b0);
      issue(C_PUSH, OP_SUB, 8'h00);
      check("full_depth", stackDepth, 3'd4);
      check("full_ovf", stackOvf, 1'b1);
      run(C_POP, 4'h0, 8'h00);
      check("pop4_acc", acc, 8'h78);
      check("pop4_carry", carryFlag, 1'b0);
      check("pop4_depth", stackDepth, 3'd3);
      run(C_POP, 4'h0, 8'h00);
      check("pop3_acc", acc, 8'h44);
      run(C_POP, 4'h0, 8'h00);
      check("pop2_acc", acc, 8'h7C);
      run(C_POP, 4'h0, 8'h00);
      check("pop1_acc", acc, 8'h3C);
      check("pop1_depth", stackDepth, 3'd0);
      check("pop1_unf", stackUnf, 1'b0);
      issue(C_POP, 4'h0, 8'h00);
      check("unf_flag", stackUnf, 1'b1);
      check("unf_aluEn", aluEn, 1'b0);
      check("unf_ready", cmdReady, 1'b1);
      check("unf_acc", acc, 8'h3C);
      check("unf_depth", stackDepth, 3'd0);
      check("unf_ovf_sticky", stackOvf, 1'b1);
      issue(C_CLRF, 4'h0, 8'h00);
      check("clrf_ovf", stackOvf, 1'b0);
      check("clrf_unf", stackUnf, 1'b0);

      // SUB borrow, then unsigned compare.
      run(C_EXEC, OP_LD, 8'h03);
      run(C_EXEC, OP_SUB, 8'h05);
      check("sub_acc", acc, 8'hFE);
      check("sub_carry", carryFlag, 1'b1);
      run(C_EXEC, OP_LT, 8'hFF);
      check("lt_acc", acc, 8'h01);
      check("lt_carry", carryFlag, 1'b1);

      // Reset in the middle of POPX.
      issue(C_PUSH, OP_ADD, 8'h00);
      issue(C_PUSH, OP_XOR, 8'h00);
      check("pre_rst_depth", stackDepth, 3'd2);
      issue(C_POP, 4'h0, 8'h00);
      check("popx_aluEn", aluEn, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_acc", acc, 8'h00);
      check("mid_rst_depth", stackDepth, 3'd0);
      check("mid_rst_aluEn", aluEn, 1'b0);
      check("mid_rst_ready", cmdReady, 1'b0);
      check("mid_rst_carry", carryFlag, 1'b0);
      check("mid_rst_opc", aluOpcode, 4'h0);
`ifdef ACC_ZERO_FLAG_EN
      check("mid_rst_zero", zeroFlag, 1'b1);
`endif
      @(negedge clk);
      reset = 1'b0;
      run(C_EXEC, OP_LD, 8'hA5);
      check("post_rst_acc", acc, 8'hA5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
